vote_result_reader: RTL and testbench
=====================================

Name: vote_result_reader

Overview:
- Read-out master for the voting machine: drives its mode/button inputs to place it in result mode, presses each candidate button in turn, and captures the 8-bit led value shown for each candidate.
- Computes the winner and a tie flag from the four captured counts.
- Presents all results to the supervisory logic (display/UART front end) through a valid/ready handshake.
- Sits beside the voting machine on the same clock; its outputs connect directly to the machine's mode and button0..button3 inputs, and its led_i input connects to the machine's led output.

Parameters:
- HOLD_CYCLES, 12, cycles each button is held; must exceed the machine's press-qualification time. Legal range 2..255.
- GAP_CYCLES, 4, idle cycles with all buttons low, after mode rises and after each release. Legal range 1..255.
- CNT_W, 8, width of led_i and of each captured count.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a read-out; sampled only in IDLE with res_valid=0.
- abort  in  1  abandon a read-out in progress.
- busy  out  1  high in every state except IDLE and DONE.
- mode_o  out  1  to machine mode; 1 = result/display mode.
- button0_o..button3_o  out  1 each  to machine button0..button3.
- led_i  in  CNT_W  machine led output.
- count0..count3  out  CNT_W each  captured counts for candidates 0..3.
- winner  out  2  index of the highest count.
- tie  out  1  maximum count shared by two or more candidates.
- res_valid  out  1  results valid.
- res_ready  in  1  consumer accepts results.

Behaviour:
- All outputs registered.
- Reset (any cycle, including mid-read-out):
  - state IDLE; mode_o=0, all buttons 0, busy=0, res_valid=0.
  - count0..3=0, winner=0, tie=0.
  - internal hold/gap counter and candidate index cleared.
- FSM states: IDLE, SETUP, PRESS, RELEASE, COMPARE, DONE.
- IDLE:
  - start=1 and res_valid=0 -> SETUP. Otherwise stay.
- SETUP:
  - mode_o=1, all buttons 0, for GAP_CYCLES cycles; index k=0.
  - Then -> PRESS.
- PRESS:
  - mode_o=1, only button k_o=1, for exactly HOLD_CYCLES cycles.
  - On the last PRESS cycle, count k <= led_i.
  - Then -> RELEASE.
- RELEASE:
  - mode_o=1, all buttons 0, for GAP_CYCLES cycles.
  - Then if k<3: k<=k+1 -> PRESS; else -> COMPARE.
- COMPARE:
  - mode_o=0, buttons 0, for 4 cycles.
  - Cycle i compares count i against the running max; strict greater-than updates max and winner.
  - Equal to max sets tie; a new strict max clears tie.
  - Result: lowest index wins among equal maxima; all-zero counts give winner=0, tie=1.
  - Then -> DONE.
- DONE:
  - res_valid=1; count/winner/tie stable.
  - res_valid=1 and res_ready=1 on the same cycle -> IDLE, res_valid=0 next cycle.
  - A start arriving in that same cycle is ignored.
- Never more than one button high; no button high while mode_o=0.
- Latency: res_valid first high GAP + 4*(HOLD+GAP) + 4 edges after the edge sampling start. Defaults: 72.
- abort=1 in SETUP/PRESS/RELEASE/COMPARE:
  - next cycle IDLE; mode_o=0, buttons 0.
  - count/winner/tie keep prior values; no res_valid.
  - abort in IDLE/DONE has no effect.
- start while busy or in DONE is ignored (no queueing).
- led_i is not sampled outside the last PRESS cycle.

Test Plan:
- Bench uses a behavioural voting-machine model with preloaded counts 2,1,0,0.
- Reset, then start pulse -> mode_o rises next cycle; button0_o high cycles 5..16, button1_o 21..32, etc. Counts read 2,1,0,0; winner=0, tie=0; res_valid at edge 72.
- Counts 3,7,7,1 -> winner=1, tie=1. Counts 0,0,0,0 -> winner=0, tie=1.
- Hold res_ready=0 for 20 cycles -> res_valid and results stable, busy=0, start ignored. res_ready=1 -> IDLE next cycle.
- abort during PRESS of candidate 2 -> buttons and mode_o low next cycle, no res_valid, counts unchanged from the previous run.
- reset asserted mid-RELEASE -> all outputs to reset values next cycle. A fresh start then completes normally in 72 edges.
- Model count 255 for candidate 3, others 254 -> count3=255, winner=3, tie=0. Assertion on every cycle: at most one button high and none while mode_o=0.

Source files
------------

// File: rtl/vote_result_reader.sv
// Read-out master for the voting machine: steps the machine through result mode,
// captures each candidate's count from led_i, then reports winner/tie via valid/ready.
module vote_result_reader #(
    parameter int HOLD_CYCLES = 12,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             mode_o,
    output logic             button0_o,
    output logic             button1_o,
    output logic             button2_o,
    output logic             button3_o,
    input  logic [CNT_W-1:0] led_i,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2,
    output logic [CNT_W-1:0] count3,
    output logic [1:0]       winner,
    output logic             tie,
    output logic             res_valid,
    input  logic             res_ready
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_PRESS   = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_COMPARE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] CMP_LAST  = 8'd3;

    logic [2:0]       state;
    logic [7:0]       cnt;
    logic [1:0]       k;
    logic [3:0]       buttons;
    logic [CNT_W-1:0] cap [4];
    logic [CNT_W-1:0] run_max;
    logic [1:0]       run_win;
    logic             run_tie;

    logic [CNT_W-1:0] cand;
    logic [CNT_W-1:0] nx_max;
    logic [1:0]       nx_win;
    logic             nx_tie;

    assign button0_o = buttons[0];
    assign button1_o = buttons[1];
    assign button2_o = buttons[2];
    assign button3_o = buttons[3];

    // One compare step per COMPARE cycle; cnt doubles as the candidate index.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        cand   = cap[cnt[1:0]];
        nx_max = run_max;
        nx_win = run_win;
        nx_tie = run_tie;
        if (cand > run_max) begin
            nx_max = cand;
            nx_win = cnt[1:0];
            nx_tie = 1'b0;
        end else if (cand == run_max) begin
            nx_tie = 1'b1;
        end
    end

    // Captures land in cap[] and are only copied to count0..3 when a read-out
    // completes, so an aborted run leaves the previous results visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the four capture registers are plain flops, so they are reset like any other state.
            state     <= S_IDLE;
            cnt       <= '0;
            k         <= '0;
            buttons   <= '0;
            mode_o    <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            count0    <= '0;
            count1    <= '0;
            count2    <= '0;
            count3    <= '0;
            winner    <= '0;
            tie       <= 1'b0;
            run_max   <= '0;
            run_win   <= '0;
            run_tie   <= 1'b0;
            for (int i = 0; i < 4; i++) cap[i] <= '0;
        end else if (abort && busy) begin
            state   <= S_IDLE;
            cnt     <= '0;
            k       <= '0;
            buttons <= '0;
            mode_o  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !res_valid) begin
                        state  <= S_SETUP;
                        mode_o <= 1'b1;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        k      <= '0;
                    end
                end
                S_SETUP: begin
                    if (cnt == GAP_LAST) begin
                        state   <= S_PRESS;
                        cnt     <= '0;
                        buttons <= 4'b0001;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_PRESS: begin
                    if (cnt == HOLD_LAST) begin
                        cap[k]  <= led_i;
                        buttons <= '0;
                        state   <= S_RELEASE;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (k == 2'd3) begin
                            state   <= S_COMPARE;
                            mode_o  <= 1'b0;
                            run_max <= '0;
                            run_win <= '0;
                            run_tie <= 1'b0;
                        end else begin
                            k       <= k + 2'd1;
                            buttons <= 4'b0001 << (k + 2'd1);
                            state   <= S_PRESS;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_COMPARE: begin
                    run_max <= nx_max;
                    run_win <= nx_win;
                    run_tie <= nx_tie;
                    if (cnt == CMP_LAST) begin
                        count0    <= cap[0];
                        count1    <= cap[1];
                        count2    <= cap[2];
                        count3    <= cap[3];
                        winner    <= nx_win;
                        tie       <= nx_tie;
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        res_valid <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    buttons <= '0;
                    mode_o  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vote_result_reader.sv
// Directed bench for vote_result_reader with a behavioural voting machine that
// shows a preloaded count on led once a result-mode button has been held a few cycles.
module tb_vote_result_reader;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       res_ready;
    logic [7:0] led_i;
    logic       busy, mode_o, button0_o, button1_o, button2_o, button3_o;
    logic [7:0] count0, count1, count2, count3;
    logic [1:0] winner;
    logic       tie, res_valid;

    logic [3:0] btn;
    logic [7:0] model [4];
    int         press_len;
    logic       armed;
    int         tests;
    int         failed;

    vote_result_reader dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .mode_o    (mode_o),
        .button0_o (button0_o),
        .button1_o (button1_o),
        .button2_o (button2_o),
        .button3_o (button3_o),
        .led_i     (led_i),
        .count0    (count0),
        .count1    (count1),
        .count2    (count2),
        .count3    (count3),
        .winner    (winner),
        .tie       (tie),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    always #5 clock = ~clock;

    assign btn = {button3_o, button2_o, button1_o, button0_o};

    // Voting machine model: led shows the held candidate's count after a short qualification.
    always @(posedge clock) begin
        if (mode_o === 1'b1 && btn != 4'b0000) begin
            if (press_len < 15) press_len <= press_len + 1;
            if (press_len >= 3) begin
                case (btn)
                    4'b0001: led_i <= model[0];
                    4'b0010: led_i <= model[1];
                    4'b0100: led_i <= model[2];
                    default: led_i <= model[3];
                endcase
            end
        end else begin
            press_len <= 0;
            led_i     <= 8'h00;
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            assert ($countones(btn) <= 1 && (mode_o === 1'b1 || btn == 4'b0000)) else begin
                failed++;
                $error("FAIL button_exclusive observed btn=%b mode=%b required one-hot-or-zero with mode", btn, mode_o);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        model[0] = a;
        model[1] = b;
        model[2] = c;
        model[3] = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mode"},    32'(mode_o), 32'd0);
        check({tag, "_buttons"}, 32'(btn), 32'd0);
        check({tag, "_busy"},    32'(busy), 32'd0);
        check({tag, "_valid"},   32'(res_valid), 32'd0);
        check({tag, "_counts"},  {count3, count2, count1, count0}, 32'd0);
        check({tag, "_winner"},  32'(winner), 32'd0);
        check({tag, "_tie"},     32'(tie), 32'd0);
    endtask

    // Full read-out: cycle-by-cycle mode/button/busy window check and res_valid latency.
    task automatic run_readout(input string tag);
        int         bad;
        int         lat;
        logic [3:0] exp_btn;
        logic       exp_mode;
        bad   = 0;
        lat   = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_mode_rise"}, 32'(mode_o), 32'd1);
        for (int n = 1; n <= 200 && lat < 0; n++) begin
            tick();
            exp_mode = (n <= 67);
            exp_btn  = 4'b0000;
            if (n >= 4 && n <= 67 && ((n - 4) % 16) < 12) exp_btn[(n - 4) / 16] = 1'b1;
            if (res_valid === 1'b1) lat = n;
            else if (mode_o !== exp_mode || btn !== exp_btn || busy !== 1'b1) bad++;
        end
        check({tag, "_timing_errs"}, 32'(bad), 32'd0);
        check({tag, "_latency"}, 32'(lat), 32'd72);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_results(input string tag, input logic [31:0] counts, input logic [1:0] w, input logic t);
        check({tag, "_counts"}, {count3, count2, count1, count0}, counts);
        check({tag, "_winner"}, 32'(winner), 32'(w));
        check({tag, "_tie"},    32'(tie), 32'(t));
    endtask

    task automatic accept(input string tag);
        res_ready = 1'b1;
        start     = 1'b1;
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_start_ignored"}, 32'(mode_o), 32'd0);
    endtask

    initial begin
        logic [31:0] snap;
        int          bad;
        tests     = 0;
        failed    = 0;
        armed     = 1'b0;
        press_len = 0;
        led_i     = 8'h00;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b0;
        set_model(8'd2, 8'd1, 8'd0, 8'd0);
        repeat (3) tick();
        armed = 1'b1;
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Baseline 2,1,0,0 read-out, then hold results with res_ready low.
        run_readout("run_2100");
        check_results("run_2100", 32'h00000102, 2'd0, 1'b0);
        snap  = {count3, count2, count1, count0};
        bad   = 0;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid !== 1'b1 || busy !== 1'b0 || mode_o !== 1'b0 ||
                {count3, count2, count1, count0} !== snap || winner !== 2'd0 || tie !== 1'b0) bad++;
        end
        start = 1'b0;
        check("done_hold_stable_errs", 32'(bad), 32'd0);
        accept("acc1");

        set_model(8'd0, 8'd0, 8'd0, 8'd0);
        run_readout("run_zero");
        check_results("run_zero", 32'h00000000, 2'd0, 1'b1);
        accept("acc2");

        set_model(8'd3, 8'd7, 8'd7, 8'd1);
        run_readout("run_3771");
        check_results("run_3771", 32'h01070703, 2'd1, 1'b1);
        accept("acc3");

        // Abort during candidate 2 press; earlier results must survive.
        set_model(8'd9, 8'd9, 8'd9, 8'd9);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (40) tick();
        check("abort_pre_btn2", 32'(btn), 32'h4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_mode", 32'(mode_o), 32'd0);
        check("abort_buttons", 32'(btn), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (res_valid !== 1'b0 || mode_o !== 1'b0) bad++;
        end
        check("abort_no_valid_errs", 32'(bad), 32'd0);
        check_results("abort_kept", 32'h01070703, 2'd1, 1'b1);

        // Reset in the middle of candidate 0 release.
        set_model(8'd5, 8'd6, 8'd7, 8'd8);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (18) tick();
        check("pre_reset_mode", 32'(mode_o), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("mid_reset");

        set_model(8'd254, 8'd254, 8'd254, 8'd255);
        run_readout("run_max");
        check_results("run_max", 32'hFFFEFEFE, 2'd3, 1'b0);
        accept("acc4");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
